// File: rtl/line_interpolator_pkg.sv
// Shared types and constants for the line interpolator: FSM state encoding,
// coordinate/error widths and servo position codes.
package line_interpolator_pkg;

  localparam int COORD_BITS_DEF     = 16;
  localparam int PULSE_NUM_BITS_DEF = 8;

  // Bresenham error term needs headroom beyond the coordinate span
  function automatic int err_bits(input int coord_bits);
    return coord_bits + 2;
  endfunction

  localparam int ERR_BITS = err_bits(COORD_BITS_DEF);

  localparam logic SERVO_POS_UP   = 1'b1;
  localparam logic SERVO_POS_DOWN = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SERVO_REQ,
    SERVO_WAIT,
    STEP_CALC,
    STEP_REQ,
    STEP_WAIT
  } line_interp_state_t;

endpackage

// File: rtl/line_interpolator_if.sv
// Command channel from upstream plus the MotorsCtrl command/handshake channel.
// The interpolator uses the slave view; its environment uses the master view.
interface line_interpolator_if
  import line_interpolator_pkg::*;
#(
  parameter int COORD_BITS       = COORD_BITS_DEF,
  parameter int PULSE_NUM_X_BITS = PULSE_NUM_BITS_DEF,
  parameter int PULSE_NUM_Y_BITS = PULSE_NUM_BITS_DEF
);
  logic                               cmd_valid;
  logic                               cmd_rdy;
  logic signed [COORD_BITS-1:0]       cmd_x;
  logic signed [COORD_BITS-1:0]       cmd_y;
  logic                               cmd_servo;

  logic signed [PULSE_NUM_X_BITS-1:0] pulse_num_x;
  logic signed [PULSE_NUM_Y_BITS-1:0] pulse_num_y;
  logic                               servo_pos;
  logic                               trigger;
  logic                               motors_rdy;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_servo, motors_rdy,
    output cmd_rdy, pulse_num_x, pulse_num_y, servo_pos, trigger
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_servo, motors_rdy,
    input  cmd_rdy, pulse_num_x, pulse_num_y, servo_pos, trigger
  );
endinterface

// File: rtl/line_interpolator_motors_cmd_handshake.sv
// Trigger/rdy sequencer for one MotorsCtrl command: raises trigger only while
// rdy is high, reports acceptance (rdy dropped) and completion (rdy back).
module line_interpolator_motors_cmd_handshake (
  input  logic clk,
  input  logic reset,
  input  logic clk_en_i,
  input  logic req_i,
  input  logic motors_rdy_i,
  output logic trigger_o,
  output logic accepted_o,
  output logic done_o
);
  logic trigger_q;
  logic pending_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trigger_q <= 1'b0;
      pending_q <= 1'b0;
    end else if (clk_en_i) begin
      if (trigger_q) begin
        if (!motors_rdy_i) begin
          trigger_q <= 1'b0;
          pending_q <= 1'b1;
        end
      end else if (pending_q) begin
        if (motors_rdy_i) pending_q <= 1'b0;
      end else if (req_i && motors_rdy_i) begin
        trigger_q <= 1'b1;
      end
    end
  end

  // Single-cycle strobes, consumed by the owner FSM on the same clock edge
  assign trigger_o  = trigger_q;
  assign accepted_o = trigger_q & ~motors_rdy_i;
  assign done_o     = pending_q & motors_rdy_i;

endmodule

// File: rtl/line_interpolator.sv
// Rasterises absolute-target line commands into unit MotorsCtrl steps using
// Bresenham, issuing a servo-only command first whenever the servo changes.
module line_interpolator
  import line_interpolator_pkg::*;
#(
  parameter int COORD_BITS       = COORD_BITS_DEF,
  parameter int PULSE_NUM_X_BITS = PULSE_NUM_BITS_DEF,
  parameter int PULSE_NUM_Y_BITS = PULSE_NUM_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  line_interpolator_if.slave           bus,
  output logic signed [COORD_BITS-1:0] pos_x,
  output logic signed [COORD_BITS-1:0] pos_y,
  output logic                         busy
);
  localparam int EB = err_bits(COORD_BITS);
  localparam int EW = EB + 1;

  line_interp_state_t state_q;

  logic signed [COORD_BITS-1:0]       tx_q, ty_q, pos_x_q, pos_y_q;
  logic signed [COORD_BITS-1:0]       pos_x_d, pos_y_d;
  logic                               servo_t_q, servo_pos_q, cmd_rdy_q;
  logic signed [EB-1:0]               dx_q, dy_q, err_q, err_d;
  logic signed [EB-1:0]               diff_x, diff_y, abs_x, abs_y;
  logic                               sx_neg_q, sy_neg_q;
  logic signed [PULSE_NUM_X_BITS-1:0] pnx_q, pnx_d;
  logic signed [PULSE_NUM_Y_BITS-1:0] pny_q, pny_d;
  logic signed [EW-1:0]               e2, dx_w, dy_w;
  logic                               step_x, step_y;
  logic                               hs_req, hs_trigger, hs_accepted, hs_done;

  always_comb begin
    diff_x = EB'(tx_q) - EB'(pos_x_q);
    diff_y = EB'(ty_q) - EB'(pos_y_q);
    abs_x  = diff_x[EB-1] ? -diff_x : diff_x;
    abs_y  = diff_y[EB-1] ? -diff_y : diff_y;
  end

  // One Bresenham iteration from the registered error term
  always_comb begin
    e2     = $signed({err_q, 1'b0});
    dx_w   = EW'(dx_q);
    dy_w   = EW'(dy_q);
    step_x = (e2 > -dy_w);
    step_y = (e2 < dx_w);
    err_d  = err_q;
    if (step_x) err_d = err_d - dy_q;
    if (step_y) err_d = err_d + dx_q;
    pnx_d = '0;
    pny_d = '0;
    if (step_x) pnx_d = sx_neg_q ? '1 : PULSE_NUM_X_BITS'(1);
    if (step_y) pny_d = sy_neg_q ? '1 : PULSE_NUM_Y_BITS'(1);
  end

  always_comb begin
    pos_x_d = pos_x_q + COORD_BITS'(pnx_q);
    pos_y_d = pos_y_q + COORD_BITS'(pny_q);
  end

  assign hs_req = (state_q == SERVO_REQ) || (state_q == STEP_REQ);

  line_interpolator_motors_cmd_handshake u_handshake (
    .clk          (clk),
    .reset        (reset),
    .clk_en_i     (clk_en),
    .req_i        (hs_req),
    .motors_rdy_i (bus.motors_rdy),
    .trigger_o    (hs_trigger),
    .accepted_o   (hs_accepted),
    .done_o       (hs_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      ty_q        <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      servo_t_q   <= SERVO_POS_UP;
      servo_pos_q <= SERVO_POS_UP;
      cmd_rdy_q   <= 1'b1;
      dx_q        <= '0;
      dy_q        <= '0;
      err_q       <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      pnx_q       <= '0;
      pny_q       <= '0;
    end else if (clk_en) begin
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            tx_q      <= bus.cmd_x;
            ty_q      <= bus.cmd_y;
            servo_t_q <= bus.cmd_servo;
            cmd_rdy_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          dx_q     <= abs_x;
          dy_q     <= abs_y;
          sx_neg_q <= diff_x[EB-1];
          sy_neg_q <= diff_y[EB-1];
          err_q    <= abs_x - abs_y;
          if (servo_t_q != servo_pos_q) begin
            pnx_q       <= '0;
            pny_q       <= '0;
            servo_pos_q <= servo_t_q;
            state_q     <= SERVO_REQ;
          end else if (abs_x == '0 && abs_y == '0) begin
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            state_q <= STEP_CALC;
          end
        end
        SERVO_REQ: begin
          if (hs_accepted) state_q <= SERVO_WAIT;
        end
        SERVO_WAIT: begin
          if (hs_done) begin
            if (dx_q == '0 && dy_q == '0) begin
              cmd_rdy_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= STEP_CALC;
            end
          end
        end
        STEP_CALC: begin
          err_q   <= err_d;
          pnx_q   <= pnx_d;
          pny_q   <= pny_d;
          state_q <= STEP_REQ;
        end
        STEP_REQ: begin
          if (hs_accepted) begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            state_q <= STEP_WAIT;
          end
        end
        STEP_WAIT: begin
          if (hs_done) begin
            if (pos_x_q == tx_q && pos_y_q == ty_q) begin
              cmd_rdy_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              state_q <= STEP_CALC;
            end
          end
        end
        default: begin
          cmd_rdy_q <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_rdy     = cmd_rdy_q;
  assign bus.pulse_num_x = pnx_q;
  assign bus.pulse_num_y = pny_q;
  assign bus.servo_pos   = servo_pos_q;
  assign bus.trigger     = hs_trigger;
  assign pos_x           = pos_x_q;
  assign pos_y           = pos_y_q;
  assign busy            = ~cmd_rdy_q;

endmodule

// File: tb/tb_line_interpolator.sv
// Directed bench for line_interpolator with a behavioural MotorsCtrl model
// (rdy drops one cycle after trigger, returns five cycles later).
module tb_line_interpolator;
  import line_interpolator_pkg::*;

  localparam int CB = 16;
  localparam int PB = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clk_en = 1'b1;
  logic signed [CB-1:0] pos_x, pos_y;
  logic busy;

  always #5 clk = ~clk;

  line_interpolator_if #(.COORD_BITS(CB), .PULSE_NUM_X_BITS(PB), .PULSE_NUM_Y_BITS(PB)) bus ();

  line_interpolator #(.COORD_BITS(CB), .PULSE_NUM_X_BITS(PB), .PULSE_NUM_Y_BITS(PB)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .busy   (busy)
  );

  // Behavioural MotorsCtrl; every accepted command is logged
  logic mdl_rdy;
  logic hold_low = 1'b0;
  int   mdl_cnt;
  int   rec_x[$];
  int   rec_y[$];
  logic rec_s[$];

  assign bus.motors_rdy = mdl_rdy & ~hold_low;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_rdy <= 1'b1;
      mdl_cnt <= 0;
    end else if (bus.motors_rdy && bus.trigger) begin
      mdl_rdy <= 1'b0;
      mdl_cnt <= 0;
      rec_x.push_back(int'(bus.pulse_num_x));
      rec_y.push_back(int'(bus.pulse_num_y));
      rec_s.push_back(bus.servo_pos);
      $display("motors cmd %0d: pnx=%0d pny=%0d servo=%0b", rec_x.size(),
               int'(bus.pulse_num_x), int'(bus.pulse_num_y), bus.servo_pos);
    end else if (!mdl_rdy) begin
      if (mdl_cnt == 4) mdl_rdy <= 1'b1;
      mdl_cnt <= mdl_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  int exp_diag_x[5]  = '{0, 1, 1, 1, 1};
  int exp_diag_y[5]  = '{0, 0, -1, 0, -1};
  int exp_steep_x[7] = '{-1, 0, -1, -1, -1, 0, -1};
  int exp_steep_y[7] = '{1, 1, 1, 1, 1, 1, 1};

  task automatic clear_log();
    rec_x.delete();
    rec_y.delete();
    rec_s.delete();
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    clk_en = 1'b1;
    hold_low = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
  endtask

  task automatic send_cmd(input int x, input int y, input logic s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cmd_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      bus.cmd_x = x[CB-1:0];
      bus.cmd_y = y[CB-1:0];
      bus.cmd_servo = s;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (bus.cmd_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy: got %0b want 1", bus.cmd_rdy); end
    n_checks++;
    if (bus.trigger !== 1'b0) begin n_fail++; $display("FAIL reset_trigger: got %0b want 0", bus.trigger); end
    n_checks++;
    if (bus.pulse_num_x !== 8'sd0 || bus.pulse_num_y !== 8'sd0) begin
      n_fail++; $display("FAIL reset_pulse: got %0d,%0d want 0,0", bus.pulse_num_x, bus.pulse_num_y);
    end
    n_checks++;
    if (bus.servo_pos !== SERVO_POS_UP) begin n_fail++; $display("FAIL reset_servo: got %0b want %0b", bus.servo_pos, SERVO_POS_UP); end
    n_checks++;
    if (pos_x !== 16'sd0 || pos_y !== 16'sd0) begin n_fail++; $display("FAIL reset_pos: got %0d,%0d want 0,0", pos_x, pos_y); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_line_x();
    bit ok;
    clear_log();
    send_cmd(3, 0, SERVO_POS_UP, ok);
    if (ok) wait_idle(300, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL line_x_done: got %0b want 1", ok); end
    n_checks++;
    if (rec_x.size() != 3) begin n_fail++; $display("FAIL line_x_count: got %0d want 3", rec_x.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < rec_x.size()) begin
        n_checks++;
        if (rec_x[i] !== 1 || rec_y[i] !== 0 || rec_s[i] !== SERVO_POS_UP) begin
          n_fail++; $display("FAIL line_x_step%0d: got %0d,%0d,%0b want 1,0,%0b", i, rec_x[i], rec_y[i], rec_s[i], SERVO_POS_UP);
        end
      end
    end
    n_checks++;
    if (int'(pos_x) !== 3 || int'(pos_y) !== 0) begin n_fail++; $display("FAIL line_x_pos: got %0d,%0d want 3,0", pos_x, pos_y); end
  endtask

  task automatic test_servo_diag();
    bit ok;
    do_reset();
    send_cmd(4, -2, SERVO_POS_DOWN, ok);
    if (ok) wait_idle(400, ok);
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL diag_done: got %0b want 1", ok); end
    n_checks++;
    if (rec_x.size() != 5) begin n_fail++; $display("FAIL diag_count: got %0d want 5", rec_x.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < rec_x.size()) begin
        n_checks++;
        if (rec_x[i] !== exp_diag_x[i] || rec_y[i] !== exp_diag_y[i] || rec_s[i] !== SERVO_POS_DOWN) begin
          n_fail++; $display("FAIL diag_cmd%0d: got %0d,%0d,%0b want %0d,%0d,%0b", i, rec_x[i], rec_y[i], rec_s[i],
                             exp_diag_x[i], exp_diag_y[i], SERVO_POS_DOWN);
        end
      end
    end
    n_checks++;
    if (int'(pos_x) !== 4 || int'(pos_y) !== -2) begin n_fail++; $display("FAIL diag_pos: got %0d,%0d want 4,-2", pos_x, pos_y); end
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_log();
    send_cmd(4, -2, SERVO_POS_DOWN, ok);
    n_checks++;
    if (ok !== 1'b1 || bus.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL zero_accept: got ok=%0b rdy=%0b want 1,0", ok, bus.cmd_rdy); end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_rdy_back: got %0b want 1", bus.cmd_rdy); end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (rec_x.size() != 0) begin n_fail++; $display("FAIL zero_no_trigger: got %0d cmds want 0", rec_x.size()); end
    n_checks++;
    if (int'(pos_x) !== 4 || int'(pos_y) !== -2) begin n_fail++; $display("FAIL zero_pos: got %0d,%0d want 4,-2", pos_x, pos_y); end
  endtask

  task automatic test_servo_then_line();
    bit ok;
    do_reset();
    send_cmd(0, 0, SERVO_POS_DOWN, ok);
    if (ok) wait_idle(300, ok);
    n_checks++;
    if (ok !== 1'b1 || rec_x.size() != 1) begin n_fail++; $display("FAIL servo_only: got ok=%0b cmds=%0d want 1,1", ok, rec_x.size()); end
    else begin
      n_checks++;
      if (rec_x[0] !== 0 || rec_y[0] !== 0 || rec_s[0] !== SERVO_POS_DOWN) begin
        n_fail++; $display("FAIL servo_only_cmd: got %0d,%0d,%0b want 0,0,%0b", rec_x[0], rec_y[0], rec_s[0], SERVO_POS_DOWN);
      end
    end
    clear_log();
    send_cmd(-5, 7, SERVO_POS_UP, ok);
    if (ok) wait_idle(500, ok);
    n_checks++;
    if (ok !== 1'b1 || rec_x.size() != 8) begin n_fail++; $display("FAIL steep_count: got ok=%0b cmds=%0d want 1,8", ok, rec_x.size()); end
    else begin
      n_checks++;
      if (rec_x[0] !== 0 || rec_y[0] !== 0 || rec_s[0] !== SERVO_POS_UP) begin
        n_fail++; $display("FAIL steep_servo: got %0d,%0d,%0b want 0,0,%0b", rec_x[0], rec_y[0], rec_s[0], SERVO_POS_UP);
      end
      for (int i = 0; i < 7; i++) begin
        n_checks++;
        if (rec_x[i+1] !== exp_steep_x[i] || rec_y[i+1] !== exp_steep_y[i] || rec_s[i+1] !== SERVO_POS_UP) begin
          n_fail++; $display("FAIL steep_step%0d: got %0d,%0d,%0b want %0d,%0d,%0b", i, rec_x[i+1], rec_y[i+1], rec_s[i+1],
                             exp_steep_x[i], exp_steep_y[i], SERVO_POS_UP);
        end
      end
    end
    n_checks++;
    if (int'(pos_x) !== -5 || int'(pos_y) !== 7) begin n_fail++; $display("FAIL steep_pos: got %0d,%0d want -5,7", pos_x, pos_y); end
  endtask

  task automatic test_rdy_hold_and_freeze();
    bit ok;
    bit bad;
    logic [47:0] snap;
    logic [47:0] now_v;
    clear_log();
    hold_low = 1'b1;
    send_cmd(-5, 9, SERVO_POS_UP, ok);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.trigger !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (ok !== 1'b1 || bad) begin n_fail++; $display("FAIL hold_no_trigger: got ok=%0b early_trigger=%0b want 1,0", ok, bad); end
    @(negedge clk);
    hold_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.trigger === 1'b1) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL hold_release_trigger: got %0b want 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.trigger === 1'b0) begin ok = 1'b1; break; end
    end
    clk_en = 1'b0;
    snap = {bus.trigger, bus.cmd_rdy, bus.servo_pos, busy, 4'd0, bus.pulse_num_x, bus.pulse_num_y, pos_x};
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      now_v = {bus.trigger, bus.cmd_rdy, bus.servo_pos, busy, 4'd0, bus.pulse_num_x, bus.pulse_num_y, pos_x};
      if (now_v !== snap || int'(pos_y) !== 8) bad = 1'b1;
    end
    n_checks++;
    if (ok !== 1'b1 || bad) begin n_fail++; $display("FAIL freeze_hold: got ok=%0b changed=%0b pos_y=%0d want 1,0,8", ok, bad, pos_y); end
    clk_en = 1'b1;
    wait_idle(300, ok);
    n_checks++;
    if (ok !== 1'b1 || rec_x.size() != 2) begin n_fail++; $display("FAIL freeze_count: got ok=%0b cmds=%0d want 1,2", ok, rec_x.size()); end
    else begin
      n_checks++;
      if (rec_x[0] !== 0 || rec_y[0] !== 1 || rec_x[1] !== 0 || rec_y[1] !== 1) begin
        n_fail++; $display("FAIL freeze_steps: got %0d,%0d %0d,%0d want 0,1 0,1", rec_x[0], rec_y[0], rec_x[1], rec_y[1]);
      end
    end
    n_checks++;
    if (int'(pos_x) !== -5 || int'(pos_y) !== 9) begin n_fail++; $display("FAIL freeze_pos: got %0d,%0d want -5,9", pos_x, pos_y); end
  endtask

  task automatic test_reset_midline();
    bit ok;
    do_reset();
    send_cmd(-5, 7, SERVO_POS_UP, ok);
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        if (rec_x.size() == 3) begin ok = 1'b1; break; end
      end
    end
    n_checks++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_reach_step3: got %0b want 1", ok); end
    n_checks++;
    if (int'(pos_x) !== -1 || int'(pos_y) !== 2 || bus.cmd_rdy !== 1'b0) begin
      n_fail++; $display("FAIL mid_pos_before: got %0d,%0d rdy=%0b want -1,2,0", pos_x, pos_y, bus.cmd_rdy);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.trigger !== 1'b0 || bus.cmd_rdy !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_ctrl: got trig=%0b rdy=%0b busy=%0b want 0,1,0", bus.trigger, bus.cmd_rdy, busy);
    end
    n_checks++;
    if (pos_x !== 16'sd0 || pos_y !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_pos: got %0d,%0d want 0,0", pos_x, pos_y); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_servo = SERVO_POS_UP;
    test_reset();
    test_line_x();
    test_servo_diag();
    test_zero_len();
    test_servo_then_line();
    test_rdy_hold_and_freeze();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
